// File: rtl/pi_spi_pkg.sv
// Shared definitions for the SPI-to-PI initiator: command codes and frame states.
package pi_spi_pkg;

  localparam logic [7:0] CMD_WR = 8'h00;
  localparam logic [7:0] CMD_RD = 8'h01;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADR2,
    ADR1,
    ADR0,
    WDAT,
    RDAT,
    DROP
  } state_t;

endpackage

// File: rtl/spi_phy.sv
// Oversampled SPI mode-0 slave front end: synchronizers, byte receiver, MISO shifter.
// byte_done pulses one cycle after the synchronized 8th SCK rise; no backpressure, the MCU owns the pace.
module spi_phy #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_ss,
  input  logic       spi_sck,
  input  logic       spi_mosi,
  output logic       ss,
  output logic       byte_done,
  output logic [7:0] rx_dat,
  input  logic       tx_load,
  input  logic [7:0] tx_dat,
  output logic       miso
);

  logic [SYNC_STAGES-1:0] ss_sync;
  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sck_q;
  logic                   sck_s;
  logic                   mosi_s;
  logic                   sck_rise;
  logic                   sck_fall;
  logic [2:0]             bit_cnt;
  logic [6:0]             rx_sh;
  logic [7:0]             tx_sh;

  assign ss       = ss_sync[SYNC_STAGES-1];
  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_q;
  assign sck_fall = ~sck_s & sck_q;

  // Chip select resets to the deselected level so nothing starts out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_sync   <= '1;
      sck_sync  <= '0;
      mosi_sync <= '0;
      sck_q     <= 1'b0;
    end else begin
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi_ss};
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sck_q     <= sck_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= 3'd0;
      rx_sh     <= 7'd0;
      rx_dat    <= 8'd0;
      byte_done <= 1'b0;
    end else begin
      byte_done <= 1'b0;
      if (ss) begin
        bit_cnt <= 3'd0;
        rx_sh   <= 7'd0;
      end else if (sck_rise) begin
        rx_sh   <= {rx_sh[5:0], mosi_s};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_done <= 1'b1;
          rx_dat    <= {rx_sh, mosi_s};
        end
      end
    end
  end

  // A load while SCK is already low has missed its falling edge, so the MSB goes out at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_sh <= 8'd0;
      miso  <= 1'b0;
    end else if (ss) begin
      tx_sh <= 8'd0;
      miso  <= 1'b0;
    end else if (tx_load) begin
      if (sck_s) begin
        tx_sh <= tx_dat;
      end else begin
        miso  <= tx_dat[7];
        tx_sh <= {tx_dat[6:0], 1'b0};
      end
    end else if (sck_fall) begin
      miso  <= tx_sh[7];
      tx_sh <= {tx_sh[6:0], 1'b0};
    end
  end

endmodule

// File: rtl/pi_spi_initiator.sv
// SPI slave to PI bus initiator: frame FSM, auto-incrementing address, read-latency tracking.
// Strobes issue two cycles after each byte completes; no backpressure, responders answer in RD_LAT cycles.
module pi_spi_initiator
  import pi_spi_pkg::*;
#(
  parameter int ADDR_W      = 24,
  parameter int RD_LAT      = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_ss,
  input  logic              spi_sck,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [ADDR_W-1:0] pi_addr,
  output logic [7:0]        pi_dato,
  output logic              pi_we_sync,
  output logic              pi_oe_sync,
  input  logic [7:0]        pi_di,
  output logic              pi_act
);

  state_t     state;
  state_t     state_nxt;
  logic       rd_q;
  logic       rd_nxt;
  logic       we_nxt;
  logic       oe_nxt;
  logic       shift_addr;
  logic       cap;
  logic [2:0] lat_cnt;
  logic       ss;
  logic       byte_done;
  logic [7:0] rx_dat;
  logic       phy_miso;

  spi_phy #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_phy (
    .clk       (clk),
    .rst_n     (rst_n),
    .spi_ss    (spi_ss),
    .spi_sck   (spi_sck),
    .spi_mosi  (spi_mosi),
    .ss        (ss),
    .byte_done (byte_done),
    .rx_dat    (rx_dat),
    .tx_load   (cap && (state == RDAT)),
    .tx_dat    (pi_di),
    .miso      (phy_miso)
  );

  assign cap      = (lat_cnt == 3'd1);
  assign pi_act   = (state != IDLE) && (state != CMD) && (state != DROP);
  assign spi_miso = (state == RDAT) && phy_miso;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rd_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      rd_q  <= rd_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    rd_nxt     = rd_q;
    we_nxt     = 1'b0;
    oe_nxt     = 1'b0;
    shift_addr = 1'b0;
    if (ss) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: state_nxt = CMD;
        CMD: begin
          if (byte_done) begin
            if ((rx_dat == CMD_WR) || (rx_dat == CMD_RD)) begin
              state_nxt = ADR2;
              rd_nxt    = (rx_dat == CMD_RD);
            end else begin
              state_nxt = DROP;
            end
          end
        end
        ADR2: begin
          if (byte_done) begin
            shift_addr = 1'b1;
            state_nxt  = ADR1;
          end
        end
        ADR1: begin
          if (byte_done) begin
            shift_addr = 1'b1;
            state_nxt  = ADR0;
          end
        end
        ADR0: begin
          // Reads fetch the first byte on entry so it is ready before the MCU clocks it out.
          if (byte_done) begin
            shift_addr = 1'b1;
            state_nxt  = rd_q ? RDAT : WDAT;
            oe_nxt     = rd_q;
          end
        end
        WDAT:    we_nxt = byte_done;
        RDAT:    oe_nxt = byte_done;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pi_addr    <= '0;
      pi_dato    <= 8'd0;
      pi_we_sync <= 1'b0;
      pi_oe_sync <= 1'b0;
      lat_cnt    <= 3'd0;
    end else begin
      pi_we_sync <= we_nxt;
      pi_oe_sync <= oe_nxt;
      if (we_nxt) pi_dato <= rx_dat;
      if (shift_addr) begin
        pi_addr <= {pi_addr[ADDR_W-9:0], rx_dat};
      end else if (pi_we_sync || cap) begin
        pi_addr <= pi_addr + ADDR_W'(1);
      end
      // Counts down so the last step lands on the cycle pi_di is valid.
      if (oe_nxt) begin
        lat_cnt <= 3'(RD_LAT + 1);
      end else if (lat_cnt != 3'd0) begin
        lat_cnt <= lat_cnt - 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_pi_spi_initiator.sv
// Scoreboard bench: MCU-side SPI driver plus a fixed-latency PI responder model.
module tb_pi_spi_initiator;

  localparam int ADDR_W = 24;
  localparam int RD_LAT = 2;
  localparam int HALF   = 10;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              spi_ss;
  logic              spi_sck;
  logic              spi_mosi;
  logic              spi_miso;
  logic [ADDR_W-1:0] pi_addr;
  logic [7:0]        pi_dato;
  logic              pi_we_sync;
  logic              pi_oe_sync;
  logic [7:0]        pi_di;
  logic              pi_act;

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_wr[$];
  logic [23:0] exp_oe[$];
  logic [7:0]  exp_miso[$];
  logic [7:0]  fr_tx[$];

  logic [7:0] rsp_dat [RD_LAT];
  logic       rsp_vld [RD_LAT];

  always #5 clk = ~clk;

  pi_spi_initiator #(
    .ADDR_W      (ADDR_W),
    .RD_LAT      (RD_LAT),
    .SYNC_STAGES (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .spi_ss     (spi_ss),
    .spi_sck    (spi_sck),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .pi_addr    (pi_addr),
    .pi_dato    (pi_dato),
    .pi_we_sync (pi_we_sync),
    .pi_oe_sync (pi_oe_sync),
    .pi_di      (pi_di),
    .pi_act     (pi_act)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rd_val(input logic [23:0] a);
    case (a)
      24'h000007: return 8'h3C;
      24'h000008: return 8'hC3;
      default:    return a[7:0] ^ 8'hA5;
    endcase
  endfunction

  // Responder: data valid exactly RD_LAT cycles after the read strobe, junk otherwise.
  always @(posedge clk) begin
    rsp_vld[0] <= pi_oe_sync;
    rsp_dat[0] <= rd_val(pi_addr);
    for (int i = 1; i < RD_LAT; i++) begin
      rsp_vld[i] <= rsp_vld[i-1];
      rsp_dat[i] <= rsp_dat[i-1];
    end
  end
  assign pi_di = rsp_vld[RD_LAT-1] ? rsp_dat[RD_LAT-1] : 8'hEE;

  always @(negedge clk) begin
    if (pi_we_sync) begin
      if (exp_wr.size() == 0) begin
        check("we_unexp", pi_we_sync, 1'b0);
      end else begin
        logic [31:0] e;
        e = exp_wr.pop_front();
        check("we_addr", pi_addr, e[31:8]);
        check("we_dat", pi_dato, e[7:0]);
      end
    end
    if (pi_oe_sync) begin
      if (exp_oe.size() == 0) check("oe_unexp", pi_oe_sync, 1'b0);
      else check("oe_addr", pi_addr, exp_oe.pop_front());
    end
  end

  task automatic add(input logic [7:0] b, input logic [7:0] m);
    fr_tx.push_back(b);
    exp_miso.push_back(m);
  endtask

  task automatic spi_xfer(input logic [7:0] tx, input int nb, output logic [7:0] rx);
    rx = 8'd0;
    for (int i = 7; i > 7 - nb; i--) begin
      spi_mosi = tx[i];
      repeat (HALF) @(negedge clk);
      rx[i] = spi_miso;
      spi_sck = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_sck = 1'b0;
    end
  endtask

  task automatic run_frame(input int last_bits, input bit do_rst, input logic act_exp);
    logic [7:0] rx;
    int         nb;
    spi_ss = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int k = 0; k < fr_tx.size(); k++) begin
      nb = ((k == fr_tx.size() - 1) && (last_bits > 0)) ? last_bits : 8;
      spi_xfer(fr_tx[k], nb, rx);
      if (nb == 8 && exp_miso.size() != 0) check("miso", rx, exp_miso.pop_front());
      if (k == 0) check("act", pi_act, act_exp);
    end
    if (do_rst) begin
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_outs", {spi_miso, pi_we_sync, pi_oe_sync, pi_act, pi_dato, pi_addr}, 64'd0);
      spi_ss   = 1'b1;
      spi_mosi = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
    end
    spi_ss   = 1'b1;
    spi_mosi = 1'b0;
    repeat (4 * HALF) @(negedge clk);
    check("act_idle", pi_act, 1'b0);
    fr_tx.delete();
  endtask

  initial begin
    repeat (80000) @(posedge clk);
    $display("FAIL watchdog: run exceeded cycle budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    spi_ss   = 1'b1;
    spi_sck  = 1'b0;
    spi_mosi = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state", {spi_miso, pi_we_sync, pi_oe_sync, pi_act, pi_dato, pi_addr}, 64'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Plain write of two bytes.
    add(8'h00, 8'h00); add(8'h00, 8'h00); add(8'h10, 8'h00); add(8'h20, 8'h00);
    add(8'hAA, 8'h00); add(8'h55, 8'h00);
    exp_wr.push_back({24'h001020, 8'hAA});
    exp_wr.push_back({24'h001021, 8'h55});
    run_frame(0, 1'b0, 1'b1);
    check("wr_addr_hold", pi_addr, 24'h001022);

    // Read of two bytes with prefetch of the third address.
    add(8'h01, 8'h00); add(8'h00, 8'h00); add(8'h00, 8'h00); add(8'h07, 8'h00);
    add(8'h00, 8'h3C); add(8'h00, 8'hC3);
    exp_oe.push_back(24'h000007);
    exp_oe.push_back(24'h000008);
    exp_oe.push_back(24'h000009);
    run_frame(0, 1'b0, 1'b1);

    // Address wrap at the top of the space.
    add(8'h00, 8'h00); add(8'hFF, 8'h00); add(8'hFF, 8'h00); add(8'hFF, 8'h00);
    add(8'h11, 8'h00); add(8'h22, 8'h00);
    exp_wr.push_back({24'hFFFFFF, 8'h11});
    exp_wr.push_back({24'h000000, 8'h22});
    run_frame(0, 1'b0, 1'b1);
    check("wrap_addr", pi_addr, 24'h000001);

    // Unknown command: frame is ignored.
    add(8'h7E, 8'h00); add(8'h00, 8'h00); add(8'h01, 8'h00); add(8'h02, 8'h00);
    add(8'h03, 8'h00);
    run_frame(0, 1'b0, 1'b0);
    check("drop_addr", pi_addr, 24'h000001);

    // Frame aborted 5 bits into the second data byte.
    add(8'h00, 8'h00); add(8'h00, 8'h00); add(8'h02, 8'h00); add(8'h00, 8'h00);
    add(8'hAA, 8'h00);
    fr_tx.push_back(8'hBB);
    exp_wr.push_back({24'h000200, 8'hAA});
    run_frame(5, 1'b0, 1'b1);
    check("abort_addr", pi_addr, 24'h000201);

    add(8'h01, 8'h00); add(8'h00, 8'h00); add(8'h00, 8'h00); add(8'h20, 8'h00);
    add(8'h00, rd_val(24'h000020));
    exp_oe.push_back(24'h000020);
    exp_oe.push_back(24'h000021);
    run_frame(0, 1'b0, 1'b1);

    // Reset pulsed in the middle of a read data byte.
    add(8'h01, 8'h00); add(8'h00, 8'h00); add(8'h01, 8'h00); add(8'h00, 8'h00);
    add(8'h00, rd_val(24'h000100));
    fr_tx.push_back(8'h00);
    exp_oe.push_back(24'h000100);
    exp_oe.push_back(24'h000101);
    run_frame(4, 1'b1, 1'b1);

    add(8'h00, 8'h00); add(8'h00, 8'h00); add(8'h00, 8'h00); add(8'h05, 8'h00);
    add(8'h99, 8'h00);
    exp_wr.push_back({24'h000005, 8'h99});
    run_frame(0, 1'b0, 1'b1);
    check("post_rst_addr", pi_addr, 24'h000006);

    check("wr_left", exp_wr.size(), 0);
    check("oe_left", exp_oe.size(), 0);
    check("miso_left", exp_miso.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pi_spi_initiator.md
Name: pi_spi_initiator

Overview:
- SPI slave toward the MCU and initiator on the PI bus.
- Converts MCU SPI frames into PI write strobes (pi_addr/pi_dato/pi_we_sync), which config, map and memory responders consume.
- Converts MCU SPI frames into PI read strobes (pi_oe_sync), returning responder data pi_di to the MCU on MISO.
- Single clock domain; SPI inputs are oversampled.

Parameters:
- ADDR_W, 24: PI address width.
- RD_LAT, 2: clk cycles from pi_oe_sync to pi_di valid. Legal range 1..3.
- SYNC_STAGES, 2: synchronizer depth on spi_ss, spi_sck and spi_mosi.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- spi_ss  in  1  chip select, active low.
- spi_sck  in  1  SPI clock, mode 0.
- spi_mosi  in  1  MCU-to-FPGA serial data.
- spi_miso  out  1  FPGA-to-MCU serial data.
- pi_addr  out  ADDR_W  PI address.
- pi_dato  out  8  PI write data.
- pi_we_sync  out  1  one-cycle write strobe.
- pi_oe_sync  out  1  one-cycle read strobe.
- pi_di  in  8  read data muxed from responders.
- pi_act  out  1  frame in progress (ss asserted, command accepted).

Behaviour:
- Reset: all outputs 0, state IDLE, shift and bit counters 0.
- Clock requirement: spi_sck period >= 8 clk and each SCK phase >= RD_LAT+4 clk. Faster SCK is unsupported and not checked.
- Sampling: mosi is sampled on the synchronized SCK rising edge. miso changes on the synchronized falling edge. Bit order MSB first.
- Byte complete: 8th rising edge since ss low or since the last byte.
- States:
  - IDLE: wait for ss low, then enter CMD.
  - CMD: byte 0x00 -> ADR2 (write). Byte 0x01 -> ADR2 (read). Any other byte -> DROP.
  - ADR2, ADR1, ADR0: address bytes, MSB first. The address register is loaded byte-wise. After ADR0 -> WDAT or RDAT.
  - WDAT: each completed byte sets pi_dato, pulses pi_we_sync one cycle, and increments pi_addr the following cycle.
  - RDAT:
    - On entry, and after the 8th rising edge of each data byte, pulse pi_oe_sync.
    - RD_LAT cycles later, capture pi_di into the tx shift register and increment pi_addr.
    - The first data byte's MSB is presented on miso before the next rising SCK edge. It is driven by the falling edge if one occurs after capture, otherwise immediately at capture.
  - DROP: ignore all bytes, no strobes.
- pi_act is 1 in ADR2..RDAT.
- Leaving a frame: ss high (synchronized) from any state -> IDLE in 1 cycle. The partial byte is discarded, no strobe is issued, and pi_addr holds its value.
- MISO: 0 in IDLE, CMD, ADRx, WDAT and DROP.
- Address wrap: 2^ADDR_W-1 increments to 0.
- pi_we_sync and pi_oe_sync are never asserted in the same cycle, and never within 2 cycles of each other.
- In RDAT, the read for the byte after the last one clocked out is prefetched and discarded when ss rises, leaving pi_addr advanced by one.
- Reset mid-frame: immediate return to reset values. A strobe in flight is truncated.

Decomposition:
- Package pi_spi_pkg:
  - command constants CMD_WR=8'h00, CMD_RD=8'h01.
  - state enum {IDLE, CMD, ADR2, ADR1, ADR0, WDAT, RDAT, DROP}.
- Sub-module spi_phy:
  - synchronizers and SCK edge detect.
  - rx shift register with byte_done pulse.
  - tx shift register with load port.
  - bit counter reset on ss.
- Top level: frame FSM, address counter, read-latency counter.

Test Plan:
- Write frame 00 00 10 20 AA 55 -> pi_we_sync twice: addr 001020 data AA, then addr 001021 data 55. No pi_oe_sync.
- Read frame 01 00 00 07 + 2 dummy bytes, responder returns 3C@000007 and C3@000008 -> MISO bytes 3C, C3. pi_oe_sync issued at 000007, 000008 and 000009 (prefetch).
- Write starting at FFFFFF with data 11, 22 -> writes FFFFFF=11 and 000000=22.
- Command byte 7E followed by 4 bytes -> no strobes, pi_act stays 0, MISO stays 0.
- ss raised after 5 bits of a write data byte -> no pi_we_sync. Next frame starts clean with the correct CMD decode.
- rst_n pulsed low mid-RDAT -> all outputs 0 within the reset assertion. The next frame operates normally.
